xorshift_stream_checker: RTL and testbench

- Receive-side counterpart of the xorshift32 PRNG used for test-pattern generation.
- Consumes a stream of 32-bit words produced by a generator that advances STEPS xorshift iterations per word.
- Self-synchronises by seeding from a received word, then predicts each following word and flags mismatches.
- Sits at the receive end of a link or storage path under test and reports lock status and error statistics.

---
 rtl/xorshift_stream_checker.sv | 172 +++++++++++++++++
 tb/tb_xorshift_stream_checker.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xorshift_stream_checker.sv
// xorshift_stream_checker
// Receive-side checker for an xorshift32 test-pattern stream. It seeds itself
// from a received word, predicts each following word and reports lock status,
// per-word error pulses and saturating error/word statistics.
module xorshift_stream_checker #(
  parameter int STEPS    = 4,
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             locked,
  output logic             err_pulse,
  output logic             lock_lost,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count,
  output logic [31:0]      expected
);

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_VERIFY = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  localparam int MR_W = $clog2(LOCK_CNT + 1);
  localparam int ER_W = $clog2(LOSS_CNT + 1);

  // One xorshift32 iteration with zero-filled, truncated shifts.
  function automatic logic [31:0] stepOnce(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // The generator advances STEPS iterations between consecutive words.
  function automatic logic [31:0] predictWord(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    for (int i = 0; i < STEPS; i++) begin
      y = stepOnce(y);
    end
    return y;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [31:0]      pred_q, pred_d;
  logic [MR_W-1:0]  matchRun_q, matchRun_d;
  logic [ER_W-1:0]  errRun_q, errRun_d;
  logic [CNT_W-1:0] errCount_q, errCount_d;
  logic [CNT_W-1:0] wordCount_q, wordCount_d;
  logic             errPulse_q, errPulse_d;
  logic             lockLost_q, lockLost_d;
  logic             locked_q;

  logic [31:0]      predIn;
  logic [31:0]      predPred;
  logic [MR_W-1:0]  matchRunInc;
  logic [ER_W-1:0]  errRunInc;
  logic [CNT_W-1:0] errCountSat;
  logic [CNT_W-1:0] wordCountSat;

  // Predictions from the received word (seeding) and from the current
  // prediction (free-running while locked), plus saturating increments.
  always_comb begin
    predIn       = predictWord(in_data);
    predPred     = predictWord(pred_q);
    matchRunInc  = matchRun_q + MR_W'(1);
    errRunInc    = errRun_q + ER_W'(1);
    errCountSat  = (errCount_q == '1) ? errCount_q : errCount_q + CNT_W'(1);
    wordCountSat = (wordCount_q == '1) ? wordCount_q : wordCount_q + CNT_W'(1);
  end

  // Next-state logic: SEARCH seeds, VERIFY confirms the seed, LOCKED tracks
  // the stream from its own prediction so one bad word costs one error.
  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    matchRun_d  = matchRun_q;
    errRun_d    = errRun_q;
    errCount_d  = errCount_q;
    wordCount_d = wordCount_q;
    errPulse_d  = 1'b0;
    lockLost_d  = 1'b0;
    if (in_valid) begin
      case (state_q)
        S_SEARCH: begin
          if (in_data != '0) begin
            pred_d     = predIn;
            matchRun_d = '0;
            state_d    = S_VERIFY;
          end
        end
        S_VERIFY: begin
          if (in_data == pred_q) begin
            pred_d     = predIn;
            matchRun_d = matchRunInc;
            if (matchRunInc == MR_W'(LOCK_CNT)) begin
              state_d  = S_LOCKED;
              errRun_d = '0;
            end
          end else if (in_data != '0) begin
            pred_d     = predIn;
            matchRun_d = '0;
          end else begin
            state_d = S_SEARCH;
            pred_d  = '0;
          end
        end
        S_LOCKED: begin
          wordCount_d = wordCountSat;
          pred_d      = predPred;
          if (in_data == pred_q) begin
            errRun_d = '0;
          end else begin
            errPulse_d = 1'b1;
            errCount_d = errCountSat;
            errRun_d   = errRunInc;
            if (errRunInc == ER_W'(LOSS_CNT)) begin
              state_d    = S_SEARCH;
              lockLost_d = 1'b1;
              pred_d     = '0;
              errRun_d   = '0;
            end
          end
        end
        default: begin
          state_d = S_SEARCH;
          pred_d  = '0;
        end
      endcase
    end
  end

  // State and output registers; reset discards lock, counters and the word
  // presented in the reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_SEARCH;
      pred_q      <= '0;
      matchRun_q  <= '0;
      errRun_q    <= '0;
      errCount_q  <= '0;
      wordCount_q <= '0;
      errPulse_q  <= 1'b0;
      lockLost_q  <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      matchRun_q  <= matchRun_d;
      errRun_q    <= errRun_d;
      errCount_q  <= errCount_d;
      wordCount_q <= wordCount_d;
      errPulse_q  <= errPulse_d;
      lockLost_q  <= lockLost_d;
      locked_q    <= (state_d == S_LOCKED);
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = errPulse_q;
  assign lock_lost  = lockLost_q;
  assign err_count  = errCount_q;
  assign word_count = wordCount_q;
  assign expected   = pred_q;

endmodule

// File: tb/tb_xorshift_stream_checker.sv
// tb_xorshift_stream_checker
// Two checker instances: A with default parameters, B with STEPS=1,
// LOCK_CNT=1 and 4-bit counters so saturation is reachable quickly.
// A behavioural model predicts every cycle's outputs into per-instance queues;
// a monitor process pops and compares them after each clock edge.
module tb_xorshift_stream_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstA, validA, rstB, validB;
  logic [31:0] dataA, dataB;
  logic        lockedA, errPulseA, lockLostA;
  logic        lockedB, errPulseB, lockLostB;
  logic [15:0] errCountA, wordCountA;
  logic [3:0]  errCountB, wordCountB;
  logic [31:0] expectedA, expectedB;

  int checks = 0;
  int failures = 0;

  xorshift_stream_checker #(.STEPS(4), .LOCK_CNT(3), .LOSS_CNT(4), .CNT_W(16)) dutA (
    .clk(clk), .rst(rstA), .in_valid(validA), .in_data(dataA),
    .locked(lockedA), .err_pulse(errPulseA), .lock_lost(lockLostA),
    .err_count(errCountA), .word_count(wordCountA), .expected(expectedA)
  );

  xorshift_stream_checker #(.STEPS(1), .LOCK_CNT(1), .LOSS_CNT(4), .CNT_W(4)) dutB (
    .clk(clk), .rst(rstB), .in_valid(validB), .in_data(dataB),
    .locked(lockedB), .err_pulse(errPulseB), .lock_lost(lockLostB),
    .err_count(errCountB), .word_count(wordCountB), .expected(expectedB)
  );

  // Reference model state: mode 0 = searching, 1 = verifying, 2 = locked.
  typedef struct {
    int          mode;
    logic [31:0] pred;
    int          mr;
    int          er;
    int          ec;
    int          wc;
    bit          ep;
    bit          ll;
  } mdl_t;

  mdl_t mA, mB;
  mdl_t qA[$];
  mdl_t qB[$];

  logic [31:0] streamA, streamB;

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [31:0] predict(input logic [31:0] x, input int steps);
    logic [31:0] y;
    y = x;
    for (int i = 0; i < steps; i++) y = xs(y);
    return y;
  endfunction

  function automatic mdl_t modelStep(input mdl_t s, input bit r, input bit v,
                                     input logic [31:0] w, input int steps,
                                     input int lockc, input int lossc, input int cmax);
    mdl_t n;
    n = s;
    n.ep = 1'b0;
    n.ll = 1'b0;
    if (r) begin
      n.mode = 0; n.pred = 0; n.mr = 0; n.er = 0; n.ec = 0; n.wc = 0;
      return n;
    end
    if (!v) return n;
    if (s.mode == 0) begin
      if (w != 0) begin
        n.mode = 1; n.pred = predict(w, steps); n.mr = 0;
      end
    end else if (s.mode == 1) begin
      if (w == s.pred) begin
        n.pred = predict(w, steps);
        n.mr = s.mr + 1;
        if (n.mr == lockc) begin
          n.mode = 2; n.er = 0;
        end
      end else if (w != 0) begin
        n.pred = predict(w, steps); n.mr = 0;
      end else begin
        n.mode = 0; n.pred = 0;
      end
    end else begin
      n.wc = (s.wc < cmax) ? s.wc + 1 : cmax;
      n.pred = predict(s.pred, steps);
      if (w == s.pred) begin
        n.er = 0;
      end else begin
        n.ep = 1'b1;
        n.ec = (s.ec < cmax) ? s.ec + 1 : cmax;
        n.er = s.er + 1;
        if (n.er == lossc) begin
          n.mode = 0; n.ll = 1'b1; n.pred = 0; n.er = 0;
        end
      end
    end
    return n;
  endfunction

  task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle. which: 0 = A only, 1 = B only, 2 = both.
  task automatic applyStimulus(input int which, input bit r, input bit v, input logic [31:0] d);
    @(negedge clk);
    rstA = 1'b0; validA = 1'b0; dataA = $urandom;
    rstB = 1'b0; validB = 1'b0; dataB = $urandom;
    if (which != 1) begin rstA = r; validA = v; dataA = d; end
    if (which != 0) begin rstB = r; validB = v; dataB = d; end
    mA = modelStep(mA, rstA, validA, dataA, 4, 3, 4, 16'hFFFF);
    mB = modelStep(mB, rstB, validB, dataB, 1, 1, 4, 15);
    qA.push_back(mA);
    qB.push_back(mB);
  endtask

  // Wait until the outputs reflect the last driven cycle.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compareVal(name, act, exp);
  endtask

  task automatic sendA(input logic [31:0] w, input int gapMax);
    int g;
    g = (gapMax > 0) ? $urandom_range(0, gapMax) : 0;
    for (int i = 0; i < g; i++) applyStimulus(0, 1'b0, 1'b0, $urandom);
    applyStimulus(0, 1'b0, 1'b1, w);
  endtask

  task automatic cleanA(input int gapMax);
    sendA(streamA, gapMax);
    streamA = predict(streamA, 4);
  endtask

  task automatic cleanB();
    applyStimulus(1, 1'b0, 1'b1, streamB);
    streamB = xs(streamB);
  endtask

  // Monitor: compare each cycle's outputs against the queued model response.
  initial begin
    mdl_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qA.size() > 0) begin
        e = qA.pop_front();
        compareVal("A.locked", {31'd0, lockedA}, {31'd0, e.mode == 2});
        compareVal("A.err_pulse", {31'd0, errPulseA}, {31'd0, e.ep});
        compareVal("A.lock_lost", {31'd0, lockLostA}, {31'd0, e.ll});
        compareVal("A.err_count", {16'd0, errCountA}, e.ec);
        compareVal("A.word_count", {16'd0, wordCountA}, e.wc);
        compareVal("A.expected", expectedA, e.pred);
      end
      if (qB.size() > 0) begin
        e = qB.pop_front();
        compareVal("B.locked", {31'd0, lockedB}, {31'd0, e.mode == 2});
        compareVal("B.err_pulse", {31'd0, errPulseB}, {31'd0, e.ep});
        compareVal("B.lock_lost", {31'd0, lockLostB}, {31'd0, e.ll});
        compareVal("B.err_count", {28'd0, errCountB}, e.ec);
        compareVal("B.word_count", {28'd0, wordCountB}, e.wc);
        compareVal("B.expected", expectedB, e.pred);
      end
    end
  end

  initial begin
    logic [31:0] seed, mask;
    int sel;
    rstA = 1'b1; rstB = 1'b1; validA = 1'b0; validB = 1'b0; dataA = '0; dataB = '0;
    mA = '{default: 0};
    mB = '{default: 0};

    applyStimulus(2, 1'b1, 1'b0, 32'd0);
    applyStimulus(2, 1'b1, 1'b1, 32'hFFFF_FFFF);
    settle();
    checkOutput("A.reset_locked", {31'd0, lockedA}, 32'd0);
    checkOutput("A.reset_expected", expectedA, 32'd0);

    // B: single-step, lock after one confirmed word.
    applyStimulus(1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    settle();
    checkOutput("B.first_pred", expectedB, 32'h0003_E01F);
    checkOutput("B.not_yet_locked", {31'd0, lockedB}, 32'd0);
    applyStimulus(1, 1'b0, 1'b1, 32'h0003_E01F);
    settle();
    checkOutput("B.locked_after_match", {31'd0, lockedB}, 32'd1);
    checkOutput("B.err_count_zero", {28'd0, errCountB}, 32'd0);

    // B: repeated lock loss and relock until the 4-bit error counter saturates.
    streamB = xs(32'h0003_E01F);
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) begin
        applyStimulus(1, 1'b0, 1'b1, 32'h1234_5678);
        streamB = xs(streamB);
      end
      cleanB();
      cleanB();
    end
    settle();
    checkOutput("B.err_count_saturated", {28'd0, errCountB}, 32'hF);

    // A: clean stream, lock after the fourth word.
    streamA = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) cleanA(0);
    settle();
    checkOutput("A.unlocked_after_3", {31'd0, lockedA}, 32'd0);
    cleanA(0);
    settle();
    checkOutput("A.locked_after_4", {31'd0, lockedA}, 32'd1);
    for (int i = 0; i < 16; i++) cleanA(3);
    settle();
    checkOutput("A.word_count_16", {16'd0, wordCountA}, 32'd16);
    checkOutput("A.err_count_0", {16'd0, errCountA}, 32'd0);

    // A: a single corrupted word costs exactly one error.
    sendA(streamA ^ 32'd1, 0);
    streamA = predict(streamA, 4);
    settle();
    checkOutput("A.single_err_pulse", {31'd0, errPulseA}, 32'd1);
    checkOutput("A.single_err_count", {16'd0, errCountA}, 32'd1);
    checkOutput("A.still_locked", {31'd0, lockedA}, 32'd1);
    cleanA(0);
    settle();
    checkOutput("A.next_word_ok", {31'd0, errPulseA}, 32'd0);

    // A: four replaced words drop lock; clean stream relocks.
    for (int k = 0; k < 4; k++) begin
      sendA(32'h1234_5678, 0);
      streamA = predict(streamA, 4);
    end
    settle();
    checkOutput("A.lock_lost_pulse", {31'd0, lockLostA}, 32'd1);
    checkOutput("A.lost_err_pulse", {31'd0, errPulseA}, 32'd1);
    checkOutput("A.unlocked", {31'd0, lockedA}, 32'd0);
    checkOutput("A.err_count_5", {16'd0, errCountA}, 32'd5);
    for (int i = 0; i < 3; i++) cleanA(2);
    cleanA(0);
    settle();
    checkOutput("A.relocked", {31'd0, lockedA}, 32'd1);
    checkOutput("A.err_count_held", {16'd0, errCountA}, 32'd5);

    // A: reset while locked with a valid word present.
    applyStimulus(0, 1'b1, 1'b1, streamA);
    streamA = predict(streamA, 4);
    settle();
    checkOutput("A.rst_locked", {31'd0, lockedA}, 32'd0);
    checkOutput("A.rst_err_count", {16'd0, errCountA}, 32'd0);
    checkOutput("A.rst_word_count", {16'd0, wordCountA}, 32'd0);
    checkOutput("A.rst_expected", expectedA, 32'd0);

    // A: zero words are ignored in SEARCH; VERIFY reseeds on a nonzero miss.
    for (int i = 0; i < 3; i++) sendA(32'd0, 1);
    settle();
    checkOutput("A.zero_expected", expectedA, 32'd0);
    seed = streamA;
    cleanA(0);
    settle();
    checkOutput("A.seed_pred", expectedA, predict(seed, 4));
    cleanA(0);
    seed = 32'hDEAD_BEEF;
    sendA(seed, 0);
    settle();
    checkOutput("A.reseed_pred", expectedA, predict(seed, 4));
    seed = predict(seed, 4);
    sendA(seed, 0);
    seed = predict(seed, 4);
    sendA(seed, 0);
    settle();
    checkOutput("A.reseed_not_locked", {31'd0, lockedA}, 32'd0);
    seed = predict(seed, 4);
    sendA(seed, 0);
    settle();
    checkOutput("A.reseed_locked", {31'd0, lockedA}, 32'd1);
    streamA = predict(seed, 4);

    // A: randomized mix of clean, corrupted, zero and foreign words.
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 25) begin
        applyStimulus(0, 1'b0, 1'b0, $urandom);
      end else if (sel < 75) begin
        cleanA(0);
      end else if (sel < 85) begin
        mask = $urandom;
        if (mask == 0) mask = 32'd1;
        sendA(streamA ^ mask, 0);
        streamA = predict(streamA, 4);
      end else if (sel < 90) begin
        sendA(32'd0, 0);
      end else begin
        sendA($urandom, 0);
      end
    end

    for (int i = 0; i < 10; i++) begin
      if (qA.size() != 0 || qB.size() != 0) @(posedge clk);
    end
    #3;
    compareVal("queue_drain", qA.size() + qB.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
